// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader:
// FSM states, error codes and frame layout.
package imem_loader_pkg;

    typedef enum logic [3:0] {
        ST_CNT_HI,
        ST_CNT_LO,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_LEN     = 2'b11;

    // Byte offsets of the header fields; payload starts at FRAME_DATA_POS.
    localparam int FRAME_CNT_HI_POS  = 0;
    localparam int FRAME_CNT_LO_POS  = 1;
    localparam int FRAME_ADDR_HI_POS = 2;
    localparam int FRAME_ADDR_LO_POS = 3;
    localparam int FRAME_DATA_POS    = 4;

    function automatic logic is_receive(input state_t s);
        return (s != ST_DONE) && (s != ST_ERR);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Pairs bytes into 16-bit words, owns the wrapping address counter and
// the registered write strobe toward instruction memory.
module loader_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        latch_hi,
    input  logic        load_addr,
    input  logic        push_word,
    input  logic [7:0]  byte_in,
    output logic [7:0]  hi_byte,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata
);

    logic [7:0]  hi_reg;
    logic [15:0] addr_cnt_reg;
    logic [15:0] addr_reg;
    logic [15:0] wdata_reg;
    logic        we_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_reg       <= '0;
            addr_cnt_reg <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            we_reg       <= 1'b0;
        end else begin
            we_reg <= push_word;
            if (clear) begin
                hi_reg       <= '0;
                addr_cnt_reg <= '0;
                addr_reg     <= '0;
                wdata_reg    <= '0;
            end else begin
                if (latch_hi)
                    hi_reg <= byte_in;
                if (load_addr)
                    addr_cnt_reg <= {hi_reg, byte_in};
                // Counter wraps naturally at 16 bits.
                if (push_word) begin
                    wdata_reg    <= {hi_reg, byte_in};
                    addr_reg     <= addr_cnt_reg;
                    addr_cnt_reg <= addr_cnt_reg + 16'd1;
                end
            end
        end
    end

    assign hi_byte    = hi_reg;
    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses count/address/payload/checksum frames, writes words
// to instruction memory and releases the CPU only after a verified image.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus,
    input  logic         reload,
    output logic         cpu_run,
    output logic         done,
    output logic         err,
    output logic [1:0]   err_code
);

    localparam logic [16:0] MAX_W     = 17'(MAX_WORDS);
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state_reg, state_next;
    logic [7:0]  csum_reg, csum_next;
    logic [15:0] tmo_reg, tmo_next;
    logic [15:0] words_reg, words_next;
    logic [1:0]  err_code_reg, err_code_next;
    logic        rx_ready_reg;
    logic        done_reg;
    logic        err_reg;
    logic        run_reg;

    logic        accept;
    logic        latch_hi, load_addr, push_word, clear;
    logic [7:0]  hi_byte;
    logic [15:0] count;

    assign accept = bus.rx_valid && rx_ready_reg;
    assign count  = {hi_byte, bus.rx_data};

    always_comb begin
        state_next    = state_reg;
        csum_next     = csum_reg;
        tmo_next      = tmo_reg;
        words_next    = words_reg;
        err_code_next = err_code_reg;
        latch_hi      = 1'b0;
        load_addr     = 1'b0;
        push_word     = 1'b0;
        clear         = 1'b0;

        // Idle watchdog only runs once a frame has started.
        if (is_receive(state_reg) && state_reg != ST_CNT_HI) begin
            if (accept) begin
                tmo_next = '0;
            end else begin
                tmo_next = tmo_reg + 16'd1;
                if (tmo_next == TMO_LIMIT) begin
                    state_next    = ST_ERR;
                    err_code_next = ERR_TIMEOUT;
                end
            end
        end

        case (state_reg)
            ST_CNT_HI: if (accept) begin
                latch_hi   = 1'b1;
                csum_next  = csum_reg ^ bus.rx_data;
                state_next = ST_CNT_LO;
            end
            ST_CNT_LO: if (accept) begin
                csum_next  = csum_reg ^ bus.rx_data;
                words_next = count;
                if ({1'b0, count} > MAX_W) begin
                    state_next    = ST_ERR;
                    err_code_next = ERR_LEN;
                end else begin
                    state_next = ST_ADDR_HI;
                end
            end
            ST_ADDR_HI: if (accept) begin
                latch_hi   = 1'b1;
                csum_next  = csum_reg ^ bus.rx_data;
                state_next = ST_ADDR_LO;
            end
            ST_ADDR_LO: if (accept) begin
                load_addr  = 1'b1;
                csum_next  = csum_reg ^ bus.rx_data;
                state_next = (words_reg == 16'd0) ? ST_CSUM : ST_DATA_HI;
            end
            ST_DATA_HI: if (accept) begin
                latch_hi   = 1'b1;
                csum_next  = csum_reg ^ bus.rx_data;
                state_next = ST_DATA_LO;
            end
            ST_DATA_LO: if (accept) begin
                push_word  = 1'b1;
                csum_next  = csum_reg ^ bus.rx_data;
                words_next = words_reg - 16'd1;
                state_next = (words_reg == 16'd1) ? ST_CSUM : ST_DATA_HI;
            end
            ST_CSUM: if (accept) begin
                if (bus.rx_data == csum_reg) begin
                    state_next = ST_DONE;
                end else begin
                    state_next    = ST_ERR;
                    err_code_next = ERR_CSUM;
                end
            end
            ST_DONE, ST_ERR: if (reload) begin
                clear         = 1'b1;
                state_next    = ST_CNT_HI;
                csum_next     = '0;
                tmo_next      = '0;
                words_next    = '0;
                err_code_next = ERR_NONE;
            end
            default: state_next = ST_CNT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_CNT_HI;
            csum_reg     <= '0;
            tmo_reg      <= '0;
            words_reg    <= '0;
            err_code_reg <= ERR_NONE;
            rx_ready_reg <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            run_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            csum_reg     <= csum_next;
            tmo_reg      <= tmo_next;
            words_reg    <= words_next;
            err_code_reg <= err_code_next;
            rx_ready_reg <= is_receive(state_next);
            done_reg     <= (state_next == ST_DONE);
            err_reg      <= (state_next == ST_ERR);
            run_reg      <= (state_next == ST_DONE);
        end
    end

    loader_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .latch_hi   (latch_hi),
        .load_addr  (load_addr),
        .push_word  (push_word),
        .byte_in    (bus.rx_data),
        .hi_byte    (hi_byte),
        .imem_we    (bus.imem_we),
        .imem_addr  (bus.imem_addr),
        .imem_wdata (bus.imem_wdata)
    );

    assign bus.rx_ready = rx_ready_reg;
    assign cpu_run      = run_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign err_code     = err_code_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes go into a queue
// that a negedge monitor drains; status outputs are checked inline.
module tb_imem_loader;
    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic       clk;
    logic       reset;
    logic       reload;
    logic       cpu_run;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    imem_loader_if bus_if ();

    int checks   = 0;
    int failures = 0;

    wr_t        exp_q[$];
    logic [7:0] byte_q[$];

    imem_loader #(
        .MAX_WORDS      (1024),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if),
        .reload   (reload),
        .cpu_run  (cpu_run),
        .done     (done),
        .err      (err),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every write strobe must match the next expected word.
    always @(negedge clk) begin
        if (bus_if.imem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h, expected no write",
                         bus_if.imem_addr, bus_if.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus_if.imem_addr !== e.addr || bus_if.imem_wdata !== e.data) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h, expected addr=%h data=%h",
                             bus_if.imem_addr, bus_if.imem_wdata, e.addr, e.data);
                end else begin
                    $display("write ok addr=%h data=%h", e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end else begin
            $display("check ok %s = %h", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
    endtask

    task automatic send_list();
        foreach (byte_q[i]) send_byte(byte_q[i]);
    endtask

    task automatic end_stream();
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic do_reload(input string tag);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check({tag, "_reload_rx_ready"}, 16'(bus_if.rx_ready), 16'd1);
        check({tag, "_reload_err"}, {13'd0, err, err_code}, 16'd0);
        check({tag, "_reload_done_run"}, {14'd0, done, cpu_run}, 16'd0);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"}, 16'(done), 16'd1);
        check({tag, "_cpu_run"}, 16'(cpu_run), 16'd1);
        check({tag, "_err"}, {13'd0, err, err_code}, 16'd0);
        check({tag, "_rx_ready"}, 16'(bus_if.rx_ready), 16'd0);
        check({tag, "_pending_writes"}, 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        reset           = 1'b0;
        reload          = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_valid = 1'b0;
        #1;
        check("reset_rx_ready", 16'(bus_if.rx_ready), 16'd0);
        check("reset_flags", {12'd0, done, err, cpu_run, bus_if.imem_we}, 16'd0);
        check("reset_err_code", 16'(err_code), 16'd0);
        check("reset_addr", bus_if.imem_addr, 16'h0000);
        check("reset_wdata", bus_if.imem_wdata, 16'h0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_rx_ready", 16'(bus_if.rx_ready), 16'd1);

        // Normal two-word load, back-to-back bytes.
        push_exp(16'h0010, 16'h1234);
        push_exp(16'h0011, 16'hABCD);
        byte_q = '{8'h00, 8'h02, 8'h00, 8'h10, 8'h12, 8'h34, 8'hAB, 8'hCD};
        send_list();
        check("normal_run_before_csum", 16'(cpu_run), 16'd0);
        send_byte(8'h52);
        end_stream();
        check_done("normal");
        do_reload("normal");

        // Same frame with a wrong checksum.
        push_exp(16'h0010, 16'h1234);
        push_exp(16'h0011, 16'hABCD);
        byte_q = '{8'h00, 8'h02, 8'h00, 8'h10, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h53};
        send_list();
        end_stream();
        check("badcsum_err", 16'(err), 16'd1);
        check("badcsum_code", 16'(err_code), 16'd1);
        check("badcsum_run_done", {14'd0, cpu_run, done}, 16'd0);
        check("badcsum_pending_writes", 16'(exp_q.size()), 16'd0);
        do_reload("badcsum");

        // Count 0x0401 exceeds 1024 words.
        byte_q = '{8'h04, 8'h01};
        send_list();
        end_stream();
        check("len_err", 16'(err), 16'd1);
        check("len_code", 16'(err_code), 16'd3);
        check("len_rx_ready", 16'(bus_if.rx_ready), 16'd0);
        do_reload("len");

        // Header then silence: error exactly on the 100th idle cycle.
        byte_q = '{8'h00, 8'h01, 8'h00, 8'h00};
        send_list();
        end_stream();
        repeat (99) @(negedge clk);
        check("timeout_err_at_99", 16'(err), 16'd0);
        @(negedge clk);
        check("timeout_err_at_100", 16'(err), 16'd1);
        check("timeout_code", 16'(err_code), 16'd2);
        do_reload("timeout");
        repeat (200) @(negedge clk);
        check("idle_cnt_hi_err", 16'(err), 16'd0);
        check("idle_cnt_hi_rx_ready", 16'(bus_if.rx_ready), 16'd1);

        // Address wrap 0xFFFF -> 0x0000; checksum 00^02^FF^FF^00^01^00^02 = 01.
        push_exp(16'hFFFF, 16'h0001);
        push_exp(16'h0000, 16'h0002);
        byte_q = '{8'h00, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01};
        send_list();
        end_stream();
        check_done("wrap");
        do_reload("wrap");

        // Zero-length image.
        byte_q = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h20};
        send_list();
        end_stream();
        check_done("zero");
        do_reload("zero");

        // Async reset mid-frame, after one word written and the next DATA_HI taken.
        push_exp(16'h0040, 16'h1122);
        byte_q = '{8'h00, 8'h03, 8'h00, 8'h40, 8'h11, 8'h22, 8'h33};
        send_list();
        end_stream();
        check("midframe_addr_before_reset", bus_if.imem_addr, 16'h0040);
        #2;
        reset = 1'b0;
        #1;
        check("async_rx_ready", 16'(bus_if.rx_ready), 16'd0);
        check("async_flags", {12'd0, done, err, cpu_run, bus_if.imem_we}, 16'd0);
        check("async_addr", bus_if.imem_addr, 16'h0000);
        check("async_wdata", bus_if.imem_wdata, 16'h0000);
        check("async_pending_writes", 16'(exp_q.size()), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rearm_rx_ready", 16'(bus_if.rx_ready), 16'd1);
        // Fresh frame: 00^01^01^00^5A^A5 = FF.
        push_exp(16'h0100, 16'h5AA5);
        byte_q = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h5A, 8'hA5, 8'hFF};
        send_list();
        end_stream();
        check_done("fresh");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
